// File: rtl/aes_pkg.sv
// Shared types and defaults for the AES core arbiter slice.
//   state_t    : arbiter sequencing states
//   owner_t    : which requester owns the round datapath
//   pick_owner : round-robin choice between the two requesters
package aes_pkg;

  localparam int unsigned AES_NUM_ROUNDS = 10;
  localparam int unsigned AES_BLOCK_W    = 128;
  localparam int unsigned AES_CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ROUND,
    DONE
  } state_t;

  typedef enum logic {
    ENC = 1'b0,
    DEC = 1'b1
  } owner_t;

  // A lone requester always wins; on a tie the one that did not go last wins.
  function automatic owner_t pick_owner(logic i_enc_req, logic i_dec_req, owner_t i_last);
    if (i_enc_req && i_dec_req) begin
      return (i_last == ENC) ? DEC : ENC;
    end
    return i_enc_req ? ENC : DEC;
  endfunction

endpackage

// File: rtl/aes_core_arbiter_if.sv
// Bundle of all non-clock signals around the AES core arbiter.
//   requester side : key_valid, enc/dec req+block in; gnt, done, result_out, busy, abort_err out
//   datapath side  : core_load, core_data_in, core_mode, core_round_en, core_round, core_last out;
//                    core_data_out in
// Modport slave is the arbiter's view; master is the surrounding environment's view.
interface aes_core_arbiter_if #(
  parameter int unsigned BLOCK_W = aes_pkg::AES_BLOCK_W,
  parameter int unsigned CNT_W   = aes_pkg::AES_CNT_W
) ();

  logic               key_valid;
  logic               enc_req;
  logic [BLOCK_W-1:0] enc_block;
  logic               dec_req;
  logic [BLOCK_W-1:0] dec_block;
  logic               enc_gnt;
  logic               dec_gnt;
  logic               enc_done;
  logic               dec_done;
  logic [BLOCK_W-1:0] result_out;
  logic               busy;
  logic               abort_err;
  logic               core_load;
  logic [BLOCK_W-1:0] core_data_in;
  logic               core_mode;
  logic               core_round_en;
  logic [CNT_W-1:0]   core_round;
  logic               core_last;
  logic [BLOCK_W-1:0] core_data_out;

  modport slave (
    input  key_valid, enc_req, enc_block, dec_req, dec_block, core_data_out,
    output enc_gnt, dec_gnt, enc_done, dec_done, result_out, busy, abort_err,
    output core_load, core_data_in, core_mode, core_round_en, core_round, core_last
  );

  modport master (
    output key_valid, enc_req, enc_block, dec_req, dec_block, core_data_out,
    input  enc_gnt, dec_gnt, enc_done, dec_done, result_out, busy, abort_err,
    input  core_load, core_data_in, core_mode, core_round_en, core_round, core_last
  );

endinterface

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and programmable rollover.
//   clk, n_rst       : clock, asynchronous active-low reset
//   i_clear          : force count to 0 (wins over enable)
//   i_count_enable   : advance; after i_rollover_val the count wraps to 1
//   i_rollover_val   : terminal count
//   o_count_out      : current count
//   o_rollover_flag  : high while the count equals i_rollover_val
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    i_clear,
  input  logic                    i_count_enable,
  input  logic [NUM_CNT_BITS-1:0] i_rollover_val,
  output logic [NUM_CNT_BITS-1:0] o_count_out,
  output logic                    o_rollover_flag
);

  logic [NUM_CNT_BITS-1:0] r_count;
  logic [NUM_CNT_BITS-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (i_clear) begin
      w_count_next = '0;
    end else if (i_count_enable) begin
      w_count_next = (r_count == i_rollover_val) ? NUM_CNT_BITS'(1)
                                                 : r_count + NUM_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count_out     = r_count;
  assign o_rollover_flag = (r_count == i_rollover_val);

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one iterative AES-128 round datapath between the SD write path (encrypt) and the
// SD read path (decrypt). Round-robin picks an owner in IDLE, LOAD hands the owner's block to
// the datapath with the initial AddRoundKey, ROUND steps NUM_ROUNDS rounds, DONE presents the
// captured result. Dropping key_valid in LOAD or ROUND aborts back to IDLE.
//   clk, n_rst : clock, asynchronous active-low reset
//   bus_if     : requester handshakes, result, status and datapath controls (slave view)
module aes_core_arbiter import aes_pkg::*; #(
  parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int unsigned BLOCK_W    = AES_BLOCK_W,
  parameter int unsigned CNT_W      = AES_CNT_W
) (
  input  logic              clk,
  input  logic              n_rst,
  aes_core_arbiter_if.slave bus_if
);

  state_t             r_state;
  state_t             w_state_next;
  owner_t             r_owner;        // also serves as last_owner for round-robin
  owner_t             w_owner_next;
  logic [BLOCK_W-1:0] r_result;

  logic               w_cnt_clear;
  logic               w_cnt_en;
  logic               w_capture;
  logic               w_last;
  logic [CNT_W-1:0]   w_count;

  logic               w_enc_gnt;
  logic               w_dec_gnt;
  logic               w_enc_done;
  logic               w_dec_done;
  logic               w_busy;
  logic               w_abort;
  logic               w_core_load;
  logic [BLOCK_W-1:0] w_core_data_in;
  logic               w_core_mode;
  logic               w_core_round_en;
  logic [CNT_W-1:0]   w_core_round;
  logic               w_core_last;

  // Count goes 0 -> 1 leaving LOAD, then 1..NUM_ROUNDS through ROUND; cleared on exit/abort.
  flex_counter #(
    .NUM_CNT_BITS(CNT_W)
  ) u_round_cnt (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_clear        (w_cnt_clear),
    .i_count_enable (w_cnt_en),
    .i_rollover_val (CNT_W'(NUM_ROUNDS)),
    .o_count_out    (w_count),
    .o_rollover_flag(w_last)
  );

  always_comb begin
    w_state_next    = r_state;
    w_owner_next    = r_owner;
    w_cnt_clear     = 1'b0;
    w_cnt_en        = 1'b0;
    w_capture       = 1'b0;
    w_enc_gnt       = 1'b0;
    w_dec_gnt       = 1'b0;
    w_enc_done      = 1'b0;
    w_dec_done      = 1'b0;
    w_busy          = 1'b0;
    w_abort         = 1'b0;
    w_core_load     = 1'b0;
    w_core_data_in  = '0;
    w_core_mode     = 1'b0;
    w_core_round_en = 1'b0;
    w_core_round    = '0;
    w_core_last     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (bus_if.key_valid && (bus_if.enc_req || bus_if.dec_req)) begin
          w_state_next = LOAD;
          w_owner_next = pick_owner(bus_if.enc_req, bus_if.dec_req, r_owner);
        end
      end

      LOAD: begin
        w_busy         = 1'b1;
        w_core_mode    = r_owner;
        w_core_load    = 1'b1;
        w_core_data_in = (r_owner == ENC) ? bus_if.enc_block : bus_if.dec_block;
        w_enc_gnt      = (r_owner == ENC);
        w_dec_gnt      = (r_owner == DEC);
        if (!bus_if.key_valid) begin
          w_abort      = 1'b1;
          w_cnt_clear  = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_cnt_en     = 1'b1;
          w_state_next = ROUND;
        end
      end

      ROUND: begin
        w_busy          = 1'b1;
        w_core_mode     = r_owner;
        w_core_round_en = 1'b1;
        w_core_round    = w_count;
        w_core_last     = w_last;
        if (!bus_if.key_valid) begin
          // Abort wins over the final-round capture: result_out keeps its old value.
          w_abort      = 1'b1;
          w_cnt_clear  = 1'b1;
          w_state_next = IDLE;
        end else if (w_last) begin
          w_capture    = 1'b1;
          w_cnt_clear  = 1'b1;
          w_state_next = DONE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end

      DONE: begin
        w_busy       = 1'b1;
        w_core_mode  = r_owner;
        w_enc_done   = (r_owner == ENC);
        w_dec_done   = (r_owner == DEC);
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= IDLE;
      r_owner  <= DEC;
      r_result <= '0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      if (w_capture) begin
        r_result <= bus_if.core_data_out;
      end
    end
  end

  assign bus_if.enc_gnt       = w_enc_gnt;
  assign bus_if.dec_gnt       = w_dec_gnt;
  assign bus_if.enc_done      = w_enc_done;
  assign bus_if.dec_done      = w_dec_done;
  assign bus_if.result_out    = r_result;
  assign bus_if.busy          = w_busy;
  assign bus_if.abort_err     = w_abort;
  assign bus_if.core_load     = w_core_load;
  assign bus_if.core_data_in  = w_core_data_in;
  assign bus_if.core_mode     = w_core_mode;
  assign bus_if.core_round_en = w_core_round_en;
  assign bus_if.core_round    = w_core_round;
  assign bus_if.core_last     = w_core_last;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Self-checking bench for aes_core_arbiter: directed scenarios with literal timing checks,
// then randomized traffic checked every cycle against an operation-phase model.
module tb_aes_core_arbiter;
  import aes_pkg::*;

  localparam int N  = 10;
  localparam int BW = 128;
  localparam int CW = 4;

  localparam logic [BW-1:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [BW-1:0] P2 = 128'hfedcba98765432100123456789abcdef;
  localparam logic [BW-1:0] P3 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [BW-1:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [BW-1:0] C2 = 128'hdeadbeef0123456789abcdefcafef00d;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  aes_core_arbiter_if #(.BLOCK_W(BW), .CNT_W(CW)) bus_if ();

  aes_core_arbiter #(
    .NUM_ROUNDS(N),
    .BLOCK_W   (BW),
    .CNT_W     (CW)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus_if(bus_if)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: an operation is a run of phases 0 (load), 1..N (rounds), N+1 (done).
  bit          m_act = 1'b0;
  int          m_ph  = 0;
  bit          m_own = 1'b1;  // last owner; DEC after reset
  logic [BW-1:0] m_res = '0;

  always @(posedge clk) begin
    if (!n_rst) begin
      m_act <= 1'b0;
      m_ph  <= 0;
      m_own <= 1'b1;
      m_res <= '0;
    end else if (!m_act) begin
      if (bus_if.key_valid && (bus_if.enc_req || bus_if.dec_req)) begin
        m_own <= (bus_if.enc_req && bus_if.dec_req) ? !m_own : bus_if.dec_req;
        m_act <= 1'b1;
        m_ph  <= 0;
      end
    end else if (m_ph <= N && !bus_if.key_valid) begin
      m_act <= 1'b0;
    end else if (m_ph == N + 1) begin
      m_act <= 1'b0;
    end else begin
      if (m_ph == N) m_res <= bus_if.core_data_out;
      m_ph <= m_ph + 1;
    end
  end

  logic          e_act, e_load, e_rnd, e_done, e_abort;
  logic [BW-1:0] e_din, e_res;
  logic [CW-1:0] e_round;
  assign e_act   = n_rst && m_act;
  assign e_load  = e_act && (m_ph == 0);
  assign e_rnd   = e_act && (m_ph >= 1) && (m_ph <= N);
  assign e_done  = e_act && (m_ph == N + 1);
  assign e_abort = e_act && (m_ph <= N) && !bus_if.key_valid;
  assign e_din   = e_load ? (m_own ? bus_if.dec_block : bus_if.enc_block) : '0;
  assign e_res   = n_rst ? m_res : '0;
  assign e_round = e_rnd ? m_ph[CW-1:0] : '0;

  // Event log used by the directed checks and the requester auto-drop.
  int   enc_gnt_cyc  = -100;
  int   dec_gnt_cyc  = -100;
  int   enc_done_cyc = -100;
  int   dec_done_cyc = -100;
  int   abort_cyc    = -100;
  int   last_cyc     = -100;
  logic [BW-1:0] ld_data = '0;
  bit   gnt_own_q[$];
  bit   mode_q[$];

  always @(negedge clk) begin
    chk("busy",          bus_if.busy,          e_act);
    chk("enc_gnt",       bus_if.enc_gnt,       e_load && !m_own);
    chk("dec_gnt",       bus_if.dec_gnt,       e_load && m_own);
    chk("enc_done",      bus_if.enc_done,      e_done && !m_own);
    chk("dec_done",      bus_if.dec_done,      e_done && m_own);
    chk("abort_err",     bus_if.abort_err,     e_abort);
    chk("core_load",     bus_if.core_load,     e_load);
    chk("core_data_in",  bus_if.core_data_in,  e_din);
    chk("core_mode",     bus_if.core_mode,     e_act && m_own);
    chk("core_round_en", bus_if.core_round_en, e_rnd);
    chk("core_round",    bus_if.core_round,    e_round);
    chk("core_last",     bus_if.core_last,     e_rnd && (m_ph == N));
    chk("result_out",    bus_if.result_out,    e_res);

    if (bus_if.enc_gnt || bus_if.dec_gnt) begin
      gnt_own_q.push_back(bus_if.dec_gnt);
      mode_q.push_back(bus_if.core_mode);
      ld_data <= bus_if.core_data_in;
    end
    if (bus_if.enc_gnt)   enc_gnt_cyc  <= cyc;
    if (bus_if.dec_gnt)   dec_gnt_cyc  <= cyc;
    if (bus_if.enc_done)  enc_done_cyc <= cyc;
    if (bus_if.dec_done)  dec_done_cyc <= cyc;
    if (bus_if.abort_err) abort_cyc    <= cyc;
    if (bus_if.core_last) last_cyc     <= cyc;
  end

  bit auto_drop = 1'b1;

  // Advance one cycle; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_drop && enc_gnt_cyc == cyc - 1) bus_if.enc_req = 1'b0;
    if (auto_drop && dec_gnt_cyc == cyc - 1) bus_if.dec_req = 1'b0;
  endtask

  task automatic do_reset();
    n_rst            = 1'b0;
    bus_if.key_valid = 1'b0;
    bus_if.enc_req   = 1'b0;
    bus_if.dec_req   = 1'b0;
    repeat (2) tick();
    n_rst = 1'b1;
  endtask

  initial begin
    int t0;
    int t1;
    int base;
    bus_if.key_valid     = 1'b0;
    bus_if.enc_req       = 1'b0;
    bus_if.dec_req       = 1'b0;
    bus_if.enc_block     = '0;
    bus_if.dec_block     = '0;
    bus_if.core_data_out = C1;

    // Single encrypt with fixed datapath output.
    do_reset();
    bus_if.key_valid = 1'b1;
    tick();
    t0 = cyc;
    bus_if.enc_block = P1;
    bus_if.enc_req   = 1'b1;
    repeat (13) tick();
    chk("A gnt latency",  enc_gnt_cyc - t0,  1);
    chk("A last cycle",   last_cyc - t0,     11);
    chk("A done latency", enc_done_cyc - t0, 12);
    chk("A load data",    ld_data,           P1);
    chk("A result",       bus_if.result_out, C1);

    // Tie after reset: ENC first, DEC after ENC's DONE.
    do_reset();
    bus_if.key_valid = 1'b1;
    tick();
    t0 = cyc;
    bus_if.enc_block = P1;
    bus_if.dec_block = P2;
    bus_if.enc_req   = 1'b1;
    bus_if.dec_req   = 1'b1;
    repeat (26) tick();
    chk("B enc gnt",  enc_gnt_cyc - t0,  1);
    chk("B enc done", enc_done_cyc - t0, 12);
    chk("B dec gnt",  dec_gnt_cyc - t0,  14);
    chk("B dec done", dec_done_cyc - t0, 25);
    chk("B dec data", ld_data,           P2);

    // Both held continuously: grants alternate.
    do_reset();
    auto_drop        = 1'b0;
    bus_if.key_valid = 1'b1;
    tick();
    base           = gnt_own_q.size();
    bus_if.enc_req = 1'b1;
    bus_if.dec_req = 1'b1;
    for (int k = 0; k < 80 && gnt_own_q.size() < base + 4; k++) tick();
    bus_if.enc_req = 1'b0;
    bus_if.dec_req = 1'b0;
    auto_drop      = 1'b1;
    chk("C grant count", gnt_own_q.size() - base, 4);
    for (int k = 0; k < 4; k++) begin
      if (gnt_own_q.size() > base + k) begin
        chk("C owner", gnt_own_q[base+k], k % 2);
        chk("C mode",  mode_q[base+k],    k % 2);
      end
    end
    repeat (14) tick();

    // Abort at round 5, then a clean re-request.
    bus_if.core_data_out = C2;
    tick();
    t0 = cyc;
    bus_if.enc_block = P3;
    bus_if.enc_req   = 1'b1;
    repeat (6) tick();
    bus_if.key_valid = 1'b0;
    #1;
    chk("D abort pulse", bus_if.abort_err,  1);
    chk("D abort round", bus_if.core_round, 5);
    tick();
    chk("D idle after abort", bus_if.busy,       0);
    chk("D result kept",      bus_if.result_out, C1);
    bus_if.key_valid = 1'b1;
    bus_if.enc_req   = 1'b1;
    t1 = cyc;
    repeat (13) tick();
    chk("D abort cycle",    abort_cyc - t0,    6);
    chk("D regrant",        enc_gnt_cyc - t1,  1);
    chk("D redone",         enc_done_cyc - t1, 12);
    chk("D new result",     bus_if.result_out, C2);

    // key_valid low in IDLE holds off the grant.
    bus_if.key_valid = 1'b0;
    tick();
    t0 = cyc;
    bus_if.enc_block = P1;
    bus_if.enc_req   = 1'b1;
    repeat (3) tick();
    chk("E no busy", bus_if.busy, 0);
    chk("E no gnt",  enc_gnt_cyc < t0, 1);
    bus_if.key_valid = 1'b1;
    repeat (2) tick();
    chk("E gnt after key", enc_gnt_cyc - t0, 4);
    repeat (12) tick();

    // Reset mid-ROUND, then a tie goes to ENC.
    tick();
    t0 = cyc;
    bus_if.enc_req = 1'b1;
    repeat (4) tick();
    n_rst          = 1'b0;
    bus_if.enc_req = 1'b1;
    bus_if.dec_req = 1'b1;
    #1;
    chk("F busy",       bus_if.busy,          0);
    chk("F round_en",   bus_if.core_round_en, 0);
    chk("F round",      bus_if.core_round,    0);
    chk("F result",     bus_if.result_out,    0);
    tick();
    n_rst = 1'b1;
    t1    = cyc;
    repeat (2) tick();
    chk("F tie to enc", enc_gnt_cyc - t1, 1);
    chk("F dec waits",  dec_gnt_cyc < t1, 1);
    repeat (30) tick();

    // Randomized traffic, key drops and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      tick();
      bus_if.core_data_out = {$urandom, $urandom, $urandom, $urandom};
      bus_if.key_valid     = ($urandom_range(0, 29) != 0);
      n_rst                = ($urandom_range(0, 399) != 0);
      if (!bus_if.enc_req) begin
        if ($urandom_range(0, 3) == 0) begin
          bus_if.enc_req   = 1'b1;
          bus_if.enc_block = {$urandom, $urandom, $urandom, $urandom};
        end
      end else if ($urandom_range(0, 29) == 0) begin
        bus_if.enc_req = 1'b0;
      end
      if (!bus_if.dec_req) begin
        if ($urandom_range(0, 3) == 0) begin
          bus_if.dec_req   = 1'b1;
          bus_if.dec_block = {$urandom, $urandom, $urandom, $urandom};
        end
      end else if ($urandom_range(0, 29) == 0) begin
        bus_if.dec_req = 1'b0;
      end
    end
    n_rst          = 1'b1;
    bus_if.enc_req = 1'b0;
    bus_if.dec_req = 1'b0;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
Shares one iterative AES-128 round datapath between two requesters: the SD write path (encrypt) and the SD read path (decrypt). Performs round-robin arbitration and latches the winner's block. Sequences the initial AddRoundKey step plus NUM_ROUNDS rounds, then returns the result with a done pulse. Sits between the SD card interface and the round datapath; the key scheduler derives the round key from core_round.

Parameters:
NUM_ROUNDS, 10, number of AES rounds after the initial AddRoundKey
BLOCK_W, 128, data block width in bits
CNT_W, 4, round counter width (must satisfy 2^CNT_W > NUM_ROUNDS)

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
key_valid  in  1  key loaded and stable; required to start and to continue an operation
enc_req  in  1  encrypt request, level; held until enc_gnt
enc_block  in  BLOCK_W  plaintext, valid while enc_req high
dec_req  in  1  decrypt request, level; held until dec_gnt
dec_block  in  BLOCK_W  ciphertext, valid while dec_req high
enc_gnt  out  1  1-cycle pulse: enc_block consumed
dec_gnt  out  1  1-cycle pulse: dec_block consumed
enc_done  out  1  1-cycle pulse: result_out valid for encrypt
dec_done  out  1  1-cycle pulse: result_out valid for decrypt
result_out  out  BLOCK_W  registered result; holds until the next done
busy  out  1  high in LOAD, ROUND and DONE
abort_err  out  1  1-cycle pulse: operation aborted because key_valid dropped
core_load  out  1  datapath loads core_data_in and applies round-0 AddRoundKey
core_data_in  out  BLOCK_W  granted block (zero when not in LOAD)
core_mode  out  1  0 = encrypt, 1 = decrypt; held for the whole operation
core_round_en  out  1  datapath advances one round this cycle
core_round  out  CNT_W  current round index, 0..NUM_ROUNDS
core_last  out  1  final round (MixColumns bypassed)
core_data_out  in  BLOCK_W  datapath state register output

Behaviour:
- Reset: all outputs 0. result_out = 0. FSM = IDLE. round count = 0. last_owner = DEC, so ENC wins the first tie.
- FSM states: IDLE, LOAD, ROUND, DONE.
- IDLE:
  - If key_valid and any request is pending, pick the owner and go to LOAD. Otherwise stay in IDLE.
  - Only one requester pending: that requester wins.
  - Both pending: the requester other than last_owner wins.
  - last_owner updates on entry to LOAD.
- LOAD (1 cycle):
  - core_load = 1, core_round = 0.
  - core_data_in = owner block; core_mode = owner.
  - Owner gnt pulses. The requester may change its block or drop req from the next cycle.
  - Next state: ROUND, with round count = 1.
- ROUND (NUM_ROUNDS cycles):
  - core_round_en = 1, core_round = count.
  - core_last = 1 when count == NUM_ROUNDS.
  - Count increments each cycle.
  - After the cycle where count == NUM_ROUNDS: capture core_data_out into result_out, reset count to 0, go to DONE.
- DONE (1 cycle):
  - Owner done pulses; result_out is stable.
  - Next state: IDLE. Arbitration happens only in IDLE.
- Latency: the request sampled in IDLE at cycle T gives gnt at T+1 and done at T+NUM_ROUNDS+2 (T+12 by default). Throughput is one block per NUM_ROUNDS+3 cycles.
- Abort: key_valid low in LOAD or ROUND causes:
  - next state IDLE, count cleared;
  - abort_err pulses for 1 cycle;
  - no done pulse; result_out unchanged.
  - A grant already given is not re-issued; the requester must re-request.
- key_valid low in DONE: the done pulse completes normally.
- Request dropped in IDLE before grant: no effect.
- core_mode is driven by the owner register, never by live req.
- Reset mid-operation: immediate return to reset values. Any pending done is lost.
- gnt and done pulses are mutually exclusive between owners and never overlap for one owner.

Decomposition:
- Package aes_pkg holds:
  - state_t enum {IDLE, LOAD, ROUND, DONE};
  - owner_t enum {ENC, DEC};
  - localparams AES_NUM_ROUNDS = 10, AES_BLOCK_W = 128.
- Round counter reuses the existing flex_counter, with rollover_val = NUM_ROUNDS and clear driven on leaving ROUND or on abort.
- Arbitration is inline; no separate arbiter module.

Test Plan:
- Single encrypt: key_valid = 1; enc_req with enc_block = 00112233445566778899aabbccddeeff at cycle 0 -> enc_gnt at 1; core_round 1..10 over cycles 2..11; core_last at 11; enc_done at 12; result_out = core_data_out sampled at 11 (with the real datapath and key 000102...0f: 69c4e0d86a7b0430d8cdb78070b4c55a).
- Simultaneous req after reset -> ENC granted first. DEC granted in the IDLE after ENC's DONE: dec_gnt at cycle 14, dec_done at 25.
- Both requesters held continuously for 4 operations -> grants alternate ENC, DEC, ENC, DEC; core_mode matches each owner.
- key_valid low at round 5 -> abort_err pulse, next cycle IDLE, no done, result_out unchanged. A re-request completes normally in 12 cycles.
- key_valid low in IDLE with enc_req high -> no gnt and busy = 0; grant follows 1 cycle after key_valid rises.
- n_rst asserted during ROUND -> all outputs 0 immediately. After release, a tie is won by ENC.
